// File: rtl/weight_mac_pkg.sv
// Shared widths, limits and FSM state type for the weight-row MAC.
package weight_mac_pkg;
  localparam int N_TAPS     = 10;
  localparam int W_WIDTH    = 10;
  localparam int X_WIDTH    = 10;
  localparam int PROD_WIDTH = 21;
  localparam int ACC_WIDTH  = 25;
  localparam int RAM_DEPTH  = 60;
  localparam int ADDR_W     = 6;
  // Highest legal row start address: the last row must fit in RAM_DEPTH.
  localparam int ADDR_LIMIT = RAM_DEPTH - N_TAPS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_MUL,
    S_SUM
  } state_t;
endpackage

// File: rtl/mac_adder_tree.sv
// Combinational balanced adder tree: ten signed 21-bit products to a 25-bit sum.
module mac_adder_tree
  import weight_mac_pkg::*;
(
  input  logic [N_TAPS-1:0][PROD_WIDTH-1:0] i_prod,
  output logic [ACC_WIDTH-1:0]              o_sum
);

  logic signed [PROD_WIDTH:0]   w_l1 [5];
  logic signed [PROD_WIDTH+1:0] w_l2 [2];
  logic signed [PROD_WIDTH+2:0] w_l3;

  // Each level sign-extends by one bit so no level can overflow.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_l1[i] = $signed({i_prod[2*i][PROD_WIDTH-1], i_prod[2*i]}) +
                $signed({i_prod[2*i+1][PROD_WIDTH-1], i_prod[2*i+1]});
    end
    w_l2[0] = $signed({w_l1[0][PROD_WIDTH], w_l1[0]}) + $signed({w_l1[1][PROD_WIDTH], w_l1[1]});
    w_l2[1] = $signed({w_l1[2][PROD_WIDTH], w_l1[2]}) + $signed({w_l1[3][PROD_WIDTH], w_l1[3]});
    w_l3    = $signed({w_l2[0][PROD_WIDTH+1], w_l2[0]}) + $signed({w_l2[1][PROD_WIDTH+1], w_l2[1]});
    o_sum   = {w_l3[PROD_WIDTH+2], w_l3} + {{3{w_l1[4][PROD_WIDTH]}}, w_l1[4]};
  end

endmodule

// File: rtl/weight_row_mac.sv
// Walks NUM_ROWS weight rows from RAM and streams one signed dot product per row.
// Optional build macro WEIGHT_MAC_RELU_EN clamps negative row sums to zero.
module weight_row_mac
  import weight_mac_pkg::*;
#(
  parameter int NUM_ROWS   = 3,
  parameter int ROW_STRIDE = 10
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [N_TAPS*X_WIDTH-1:0]   i_x,
  input  logic [ADDR_W-1:0]           i_base_addr,
  output logic [ADDR_W-1:0]           o_ram_address,
  output logic                        o_ram_we,
  input  logic [N_TAPS*W_WIDTH-1:0]   i_ram_q,
  output logic                        o_busy,
  output logic                        o_out_valid,
  output logic [2:0]                  o_out_index,
  output logic [ACC_WIDTH-1:0]        o_out_data,
  output logic                        o_done,
  output logic                        o_error
);

  state_t r_state, w_state_nxt;

  logic [2:0]                        r_row;
  logic [N_TAPS*X_WIDTH-1:0]         r_x_p0;
  logic [ADDR_W-1:0]                 r_base_p0;
  logic [ADDR_W-1:0]                 r_addr;
  logic [N_TAPS-1:0][PROD_WIDTH-1:0] r_prod_p1;
  logic [ACC_WIDTH-1:0]              w_sum_p2;
  logic [ACC_WIDTH-1:0]              r_data_p2;
  logic [2:0]                        r_index_p2;
  logic                              r_vld_p2;
  logic                              r_done, r_busy, r_error;

  logic [ADDR_W:0]   w_last_addr;
  logic              w_reject, w_accept, w_last_row;
  logic [2:0]        w_next_row;
  logic [ADDR_W-1:0] w_next_addr;

  function automatic logic signed [PROD_WIDTH-1:0] mul_tap(input logic [W_WIDTH-1:0] w,
                                                           input logic [X_WIDTH-1:0] x);
    logic signed [PROD_WIDTH-1:0] ws, xs;
    ws = {{(PROD_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w};
    xs = {{(PROD_WIDTH-X_WIDTH){1'b0}}, x};
    return ws * xs;
  endfunction

  function automatic logic [ACC_WIDTH-1:0] apply_act(input logic [ACC_WIDTH-1:0] s);
`ifdef WEIGHT_MAC_RELU_EN
    return s[ACC_WIDTH-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  assign w_last_addr = {1'b0, i_base_addr} + 7'(ROW_STRIDE * (NUM_ROWS - 1));
  assign w_reject    = w_last_addr > 7'(ADDR_LIMIT);
  assign w_accept    = (r_state == S_IDLE) && i_start && !w_reject;
  assign w_last_row  = r_row == 3'(NUM_ROWS - 1);
  assign w_next_row  = r_row + 3'd1;
  assign w_next_addr = r_base_p0 + 6'(ROW_STRIDE) * {3'b000, w_next_row};

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_ADDR;
      S_ADDR: w_state_nxt = S_MUL;
      S_MUL:  w_state_nxt = S_SUM;
      S_SUM:  w_state_nxt = w_last_row ? S_IDLE : S_ADDR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: accept request, latch operands, present row address during ADDR.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row   <= '0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_error <= (r_state == S_IDLE) && i_start && w_reject;
      if (w_accept) begin
        r_row  <= '0;
        r_addr <= i_base_addr;
        r_busy <= 1'b1;
      end else if (r_state == S_SUM) begin
        if (w_last_row) begin
          r_busy <= 1'b0;
        end else begin
          r_row  <= w_next_row;
          r_addr <= w_next_addr;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_x_p0    <= i_x;
      r_base_p0 <= i_base_addr;
    end
  end

  // Stage p1: RAM data valid in MUL; register the ten products.
  always_ff @(posedge i_clk) begin
    if (r_state == S_MUL) begin
      for (int i = 0; i < N_TAPS; i++) begin
        r_prod_p1[i] <= mul_tap(i_ram_q[i*W_WIDTH +: W_WIDTH], r_x_p0[i*X_WIDTH +: X_WIDTH]);
      end
    end
  end

  mac_adder_tree u_tree (
    .i_prod (r_prod_p1),
    .o_sum  (w_sum_p2)
  );

  // Stage p2: reduce products and publish the row result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p2   <= 1'b0;
      r_done     <= 1'b0;
      r_index_p2 <= '0;
      r_data_p2  <= '0;
    end else begin
      r_vld_p2 <= 1'b0;
      r_done   <= 1'b0;
      if (r_state == S_SUM) begin
        r_vld_p2   <= 1'b1;
        r_done     <= w_last_row;
        r_index_p2 <= r_row;
        r_data_p2  <= apply_act(w_sum_p2);
      end
    end
  end

  assign o_ram_address = r_addr;
  assign o_ram_we      = 1'b0;
  assign o_busy        = r_busy;
  assign o_out_valid   = r_vld_p2;
  assign o_out_index   = r_index_p2;
  assign o_out_data    = r_data_p2;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: tb/tb_weight_row_mac.sv
// Self-checking bench for weight_row_mac: fixed row vectors, corner sequences, random jobs.
`timescale 1ns/1ps
module tb_weight_row_mac;
  localparam int NR = 3;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [99:0]  x;
  logic [5:0]   base;
  logic [5:0]   ram_addr;
  logic         ram_we;
  logic [99:0]  ram_q;
  logic         busy, ov, done, err;
  logic [2:0]   oidx;
  logic [24:0]  odata;

  logic [9:0]   mem [0:59];

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  weight_row_mac #(.NUM_ROWS(NR), .ROW_STRIDE(10)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_x           (x),
    .i_base_addr   (base),
    .o_ram_address (ram_addr),
    .o_ram_we      (ram_we),
    .i_ram_q       (ram_q),
    .o_busy        (busy),
    .o_out_valid   (ov),
    .o_out_index   (oidx),
    .o_out_data    (odata),
    .o_done        (done),
    .o_error       (err)
  );

  // Registered-read RAM: ten consecutive words starting at the address.
  always @(posedge clk) begin
    for (int i = 0; i < 10; i++)
      ram_q[i*10 +: 10] <= (int'(ram_addr) + i < 60) ? mem[int'(ram_addr) + i] : 10'd0;
  end

  function automatic int relu(input int v);
`ifdef WEIGHT_MAC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int model_row(input int b, input int k, input logic [99:0] xv);
    int s = 0;
    for (int i = 0; i < 10; i++)
      s += int'($signed(mem[b + 10*k + i])) * int'(xv[10*i +: 10]);
    return relu(s);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_we"}, ram_we, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, ov, 0);
    chk({tag, "_index"}, oidx, 0);
    chk({tag, "_data"}, $signed(odata), 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, err, 0);
  endtask

  // Called at a negedge; returns at the negedge where Done is visible.
  task automatic do_job(input logic [5:0] b, input logic [99:0] xv, input bit poke);
    int e;
    bit vexp;
    start = 1'b1; base = b; x = xv;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j <= 3*NR; j++) begin
      if (j > 0) @(negedge clk);
      vexp = (j >= 3) && (j % 3 == 0);
      chk("busy", busy, (j < 3*NR) ? 1 : 0);
      chk("done", done, (j == 3*NR) ? 1 : 0);
      chk("error", err, 0);
      chk("we", ram_we, 0);
      chk("valid", ov, vexp ? 1 : 0);
      if (vexp) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        if (ov) begin
          chk("index", oidx, j/3 - 1);
          chk("data", $signed(odata), e);
        end
      end
      if (j % 3 == 0 && j < 3*NR) chk("addr", ram_addr, int'(b) + 10*(j/3));
      if (poke && j == 4) begin
        start = 1'b1; base = 6'd5; x = {$urandom, $urandom, $urandom, $urandom};
      end else if (poke && j == 5) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic reject_job(input logic [5:0] b);
    logic [5:0] prev;
    prev = ram_addr;
    start = 1'b1; base = b;
    @(negedge clk);
    start = 1'b0;
    chk("rej_error", err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_addr", ram_addr, prev);
    @(negedge clk);
    chk("rej_error_drop", err, 0);
    chk("rej_busy2", busy, 0);
    chk("rej_valid", ov, 0);
  endtask

  typedef struct {
    logic [9:0]      xv;
    logic [2:0][9:0] wa;
    logic [2:0][9:0] wb;
    int              e0, e1, e2;
  } vec_t;

  vec_t tbl [4];

  task automatic load_rows(input logic [2:0][9:0] wa, input logic [2:0][9:0] wb);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 10; i++)
        mem[10*k + i] = (i % 2 == 0) ? wa[k] : wb[k];
  endtask

  task automatic push_tbl(input int n);
    exp_q.push_back(tbl[n].e0);
    exp_q.push_back(tbl[n].e1);
    exp_q.push_back(tbl[n].e2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  rb;
    logic [99:0] rx;

    tbl[0] = '{xv: 10'd1,    wa: {10'h3e0, 10'h155, 10'h2aa}, wb: {10'h3e0, 10'h155, 10'h155},
               e0: relu(-5),  e1: 3410, e2: relu(-320)};
    tbl[1] = '{xv: 10'd2,    wa: {10'h3e0, 10'h155, 10'h2aa}, wb: {10'h3e0, 10'h155, 10'h155},
               e0: relu(-10), e1: 6820, e2: relu(-640)};
    tbl[2] = '{xv: 10'd1023, wa: {10'h1ff, 10'h1ff, 10'h1ff}, wb: {10'h1ff, 10'h1ff, 10'h1ff},
               e0: 5227530, e1: 5227530, e2: 5227530};
    tbl[3] = '{xv: 10'd1023, wa: {10'h200, 10'h200, 10'h200}, wb: {10'h200, 10'h200, 10'h200},
               e0: relu(-5237760), e1: relu(-5237760), e2: relu(-5237760)};

    for (int i = 0; i < 60; i++) mem[i] = 10'd0;
    rst = 1'b1; start = 1'b0; x = '0; base = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 4; n++) begin
      load_rows(tbl[n].wa, tbl[n].wb);
      push_tbl(n);
      do_job(6'd0, {10{tbl[n].xv}}, 1'b0);
      @(negedge clk);
    end

    // Start pulsed while busy, then back-to-back Start right after Done.
    load_rows(tbl[0].wa, tbl[0].wb);
    push_tbl(0);
    do_job(6'd0, {10{tbl[0].xv}}, 1'b1);
    load_rows(tbl[1].wa, tbl[1].wb);
    push_tbl(1);
    do_job(6'd0, {10{tbl[1].xv}}, 1'b0);
    @(negedge clk);

    reject_job(6'd40);
    reject_job(6'd31);

    // Reset during MUL of row 1 discards the job.
    load_rows(tbl[0].wa, tbl[0].wb);
    start = 1'b1; base = 6'd0; x = {10{10'd1}};
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("midrst_nodone", done, 0);
      chk("midrst_novalid", ov, 0);
    end
    push_tbl(0);
    do_job(6'd0, {10{tbl[0].xv}}, 1'b0);
    @(negedge clk);

    // Random RAM contents, vectors and base addresses against the model.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 60; i++) mem[i] = 10'($urandom);
      rb = 6'($urandom_range(0, 38));
      rx = {$urandom, $urandom, $urandom, $urandom};
      if (rb > 6'd30) begin
        reject_job(rb);
      end else begin
        for (int k = 0; k < NR; k++) exp_q.push_back(model_row(int'(rb), k, rx));
        do_job(rb, rx, r[0]);
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
